// File: rtl/uart_pkg.sv
// Shared types and rate helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  localparam logic [1:0] RATE_16X = 2'd0;
  localparam logic [1:0] RATE_8X  = 2'd1;
  localparam logic [1:0] RATE_4X  = 2'd2;
  localparam logic [1:0] RATE_2X  = 2'd3;

  function automatic logic [4:0] osr_of(input logic [1:0] rate);
    logic [4:0] osr;
    case (rate)
      RATE_16X: osr = 5'd16;
      RATE_8X:  osr = 5'd8;
      RATE_4X:  osr = 5'd4;
      default:  osr = 5'd2;
    endcase
    return osr;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], rx_i};
    prev_d = sync_q[1];
  end

  // Reset to the idle-high level so release never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_sync_o = sync_q[1];
  assign fall_o    = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx_parity.sv
// Oversampling UART receiver. Define UART_RX_PARITY_EN to add a parity bit
// (and parity check) between the data bits and the stop bit.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  input  logic [1:0]           rate_i,
  input  logic                 parity_odd_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  logic rx_s, rx_fall;

  uart_rx_sync u_sync (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rx_i      (rx_i),
    .rx_sync_o (rx_s),
    .fall_o    (rx_fall)
  );

  uart_rx_state_t       state_q, state_d;
  logic [3:0]           s_cnt_q, s_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           rate_q, rate_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
`endif

  // Sample points use the ratio latched at the start edge, not the live input.
  logic [4:0] osr, half_m1, last_m1;
  logic       at_half, at_last;

  always_comb begin
    osr     = osr_of(rate_q);
    half_m1 = (osr >> 1) - 5'd1;
    last_m1 = osr - 5'd1;
    at_half = ({1'b0, s_cnt_q} == half_m1);
    at_last = ({1'b0, s_cnt_q} == last_m1);
  end

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    rate_d    = rate_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
    busy_d    = busy_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          s_cnt_d = '0;
          rate_d  = rate_i;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tick_i) begin
          if (at_half) begin
            s_cnt_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick_i) begin
          if (at_last) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            s_cnt_d   = '0;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_i) begin
          if (at_last) begin
            par_bad_d = ((^shift_q) ^ rx_s) != parity_odd_i;
            s_cnt_d   = '0;
            state_d   = STOP;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick_i) begin
          if (at_last) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_bad_q;
`endif
            busy_d  = 1'b0;
            s_cnt_d = '0;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      rate_q    <= RATE_16X;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rate_q    <= rate_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity: frames with hand-computed results at
// several ratios, parity/framing errors, glitch rejection and mid-frame reset.
module tb_uart_rx_parity;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       tick_i = 1'b1;
  logic [1:0] rate_i;
  logic       parity_odd_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o, parity_err_o, frame_err_o, busy_o;

  uart_rx_parity #(.DATA_BITS(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tick_i       (tick_i),
    .rate_i       (rate_i),
    .parity_odd_i (parity_odd_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int tdiv  = 1;
  int tcnt  = 0;
  int vcnt  = 0;
  logic [7:0] last_data = '0;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;

`ifdef UART_RX_PARITY_EN
  localparam logic BAD_PAR = 1'b1;
`else
  localparam logic BAD_PAR = 1'b0;
`endif

  // Tick generator: high every cycle, or one cycle in every tdiv.
  always @(negedge clk_i) begin
    if (tdiv <= 1) tick_i = 1'b1;
    else begin
      tcnt   = (tcnt + 1) % tdiv;
      tick_i = (tcnt == 0);
    end
  end

  always @(negedge clk_i) begin
    if (valid_o) begin
      vcnt      = vcnt + 1;
      last_data = data_o;
      last_perr = parity_err_o;
      last_ferr = frame_err_o;
    end
  end

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_v,
                            input int stop_len, input int osr);
    int bp;
    bp = osr * tdiv;
    hold(1'b0, bp);
    for (int i = 0; i < 8; i++) hold(d[i], bp);
`ifdef UART_RX_PARITY_EN
    hold(p, bp);
`endif
    hold(stop_v, stop_len * bp);
    hold(1'b1, 3 * bp);
  endtask

  task automatic chk_frame(input string nm, input int v0, input logic [7:0] d,
                           input logic pe, input logic fe);
    n_cmp++;
    if (vcnt - v0 !== 1) begin
      n_err++; $display("FAIL %s strobes: got %0d want 1", nm, vcnt - v0);
    end
    n_cmp++;
    if (last_data !== d) begin
      n_err++; $display("FAIL %s data: got %h want %h", nm, last_data, d);
    end
    n_cmp++;
    if (last_perr !== pe) begin
      n_err++; $display("FAIL %s parity_err: got %b want %b", nm, last_perr, pe);
    end
    n_cmp++;
    if (last_ferr !== fe) begin
      n_err++; $display("FAIL %s frame_err: got %b want %b", nm, last_ferr, fe);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL %s busy_after: got %b want 0", nm, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; rx_i = 1'b1; rate_i = 2'd0; parity_odd_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({data_o, valid_o, parity_err_o, frame_err_o, busy_o} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b want 00/0000",
               data_o, valid_o, parity_err_o, frame_err_o, busy_o);
    end
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic test_parity();
    int v0;
    v0 = vcnt; send_frame(8'hA5, 1'b0, 1'b1, 1, 16);
    chk_frame("even_ok", v0, 8'hA5, 1'b0, 1'b0);
    v0 = vcnt; send_frame(8'hA5, 1'b1, 1'b1, 1, 16);
    chk_frame("even_bad", v0, 8'hA5, BAD_PAR, 1'b0);
    parity_odd_i = 1'b1;
    v0 = vcnt; send_frame(8'hA5, 1'b1, 1'b1, 1, 16);
    chk_frame("odd_ok", v0, 8'hA5, 1'b0, 1'b0);
    parity_odd_i = 1'b0;
  endtask

  task automatic test_frame_err();
    int v0;
    v0 = vcnt;
    send_frame(8'h3C, 1'b0, 1'b0, 2, 16);
    chk_frame("stop_err", v0, 8'h3C, 1'b0, 1'b1);
    hold(1'b1, 64);
    n_cmp++;
    if (vcnt - v0 !== 1) begin
      n_err++; $display("FAIL break_no_retrigger: got %0d strobes want 1", vcnt - v0);
    end
    n_cmp++;
    if (data_o !== 8'h3C || frame_err_o !== 1'b1) begin
      n_err++; $display("FAIL hold_outputs: got %h/%b want 3c/1", data_o, frame_err_o);
    end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = vcnt;
    hold(1'b0, 4);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL glitch_busy_rise: got %b want 1", busy_o);
    end
    hold(1'b1, 40);
    n_cmp++;
    if (vcnt !== v0) begin
      n_err++; $display("FAIL glitch_strobe: got %0d strobes want 0", vcnt - v0);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL glitch_busy_fall: got %b want 0", busy_o);
    end
  endtask

  task automatic test_rates();
    int v0;
    tdiv = 3;
    rate_i = 2'd3;
    v0 = vcnt; send_frame(8'h81, 1'b0, 1'b1, 1, 2);
    chk_frame("osr2", v0, 8'h81, 1'b0, 1'b0);
    rate_i = 2'd1;
    v0 = vcnt; send_frame(8'h7E, 1'b0, 1'b1, 1, 8);
    chk_frame("osr8", v0, 8'h7E, 1'b0, 1'b0);
    tdiv = 1;
    rate_i = 2'd0;
  endtask

  task automatic test_reset_mid();
    int v0;
    v0 = vcnt;
    hold(1'b0, 16);
    hold(1'b1, 3 * 16 + 8);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL mid_busy: got %b want 1", busy_o);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({data_o, valid_o, parity_err_o, frame_err_o, busy_o} !== 12'h0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %h/%b%b%b%b want 00/0000",
               data_o, valid_o, parity_err_o, frame_err_o, busy_o);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    hold(1'b1, 200);
    n_cmp++;
    if (vcnt !== v0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL mid_abort: got strobes %0d busy %b want 0 0", vcnt - v0, busy_o);
    end
    v0 = vcnt; send_frame(8'h55, 1'b0, 1'b1, 1, 16);
    chk_frame("after_reset", v0, 8'h55, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_parity();
    test_frame_err();
    test_glitch();
    test_rates();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
# uart_rx_parity

UART receiver with optional parity check. It recovers serial frames from `rx_i` using the oversampling tick from the project's fractional tick generator (`tick_i`, one pulse per oversample period). It delivers each received word with parity and framing status as a one-cycle `valid_o` strobe. It is the receive-side counterpart of the tick generator in the UART_parity design and uses the same `rate_i` encoding for oversampling ratio.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first; legal range 5..9.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `tick_i`  in  1  oversample tick, one clk-cycle pulse; may be tied high.
- `rate_i`  in  2  oversample ratio: 0 gives OSR 16, 1 gives 8, 2 gives 4, 3 gives 2.
- `parity_odd_i`  in  1  0 = even parity, 1 = odd parity; ignored when parity is compiled out.
- `rx_i`  in  1  asynchronous serial line, idle high.
- `data_o`  out  DATA_BITS  last received word.
- `valid_o`  out  1  one-cycle strobe when a frame completes.
- `parity_err_o`  out  1  parity status of the last frame.
- `frame_err_o`  out  1  stop-bit status of the last frame.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- `rx_i` passes through a 2-flop synchronizer; both flops reset to 1. The block keeps the previous synced value for falling-edge detection.
- States are IDLE, START, DATA, PARITY, STOP.
- `s_cnt` counts `tick_i` pulses and is sized for OSR 16. `bit_cnt` counts data bits.
- IDLE:
  - A synced 1→0 transition moves the state to START.
  - On that transition, `s_cnt` clears and `rate_i` is latched as OSR for the whole frame.
- START: on the tick where `s_cnt == OSR/2-1`, sample the synced line.
  - Line is 0: go to DATA with `s_cnt=0` and `bit_cnt=0`.
  - Line is 1: this is a glitch. Return to IDLE with no strobe.
- DATA:
  - On each tick where `s_cnt == OSR-1`, shift the sample in at the MSB (LSB-first reassembly) and clear `s_cnt`.
  - After DATA_BITS samples, go to PARITY if parity is compiled in, otherwise to STOP.
- PARITY:
  - Sample bit p at `s_cnt == OSR-1`.
  - Error flag = `(^shift ^ p) != parity_odd_i`.
- STOP:
  - Sample at `s_cnt == OSR-1`; frame error = sampled value is 0.
  - Then return to IDLE.
- Frame completion:
  - Data is delivered even when either error flag is set.
  - A stop bit of 0 (break) does not retrigger a start. IDLE needs a fresh 1→0 edge.
- `tick_i` pulses that arrive in IDLE are ignored.
- A `rate_i` change mid-frame takes effect at the next start.

## Timing
- Reset values: `data_o=0`, `valid_o=0`, `parity_err_o=0`, `frame_err_o=0`, `busy_o=0`, state IDLE, shift register 0.
- Latency:
  - Synchronizer: 2 clk cycles from `rx_i` to the synced line.
  - Output: `valid_o`, `data_o` and both error flags are registered and update on the clk edge after the tick that samples the stop bit.
- `valid_o` is high for exactly 1 cycle per frame. The receiver has no backpressure; downstream must consume the word on the strobe.
- `data_o` and both error flags hold until the next frame completes.
- `busy_o` is registered. It rises the cycle after the start edge is detected and falls together with the `valid_o` assertion (or on glitch rejection).
- Reset asserted mid-frame aborts the frame immediately with no strobe. After release, reception needs a fresh start edge.
- Bit-center sampling: the start bit is sampled at OSR/2 ticks after its edge. Each following sample is OSR ticks after the previous one.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: frame is start + DATA_BITS + parity + stop. `parity_err_o` is computed as above.
- Undefined:
  - PARITY state is removed; frame is start + DATA_BITS + stop.
  - `parity_err_o` is tied 0 and `parity_odd_i` is unused.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - the rate encoding constants `RATE_16X`..`RATE_2X`;
  - function `osr_of(rate)`, returning 16/8/4/2.
- Sub-module `uart_rx_sync` contains the 2-flop synchronizer plus the falling-edge detect output.

## Test plan
- **Even parity, valid frame:** UART_RX_PARITY_EN defined, rate 0, `tick_i`=1. Send 0xA5 with parity bit 0 and stop bit 1. Expect one `valid_o` pulse, `data_o=0xA5`, `parity_err_o=0`, `frame_err_o=0`.
- **Even parity, bad parity bit:** send 0xA5 with parity bit 1. Expect `data_o=0xA5` and `parity_err_o=1`. Repeat with `parity_odd_i=1` and parity bit 1; expect `parity_err_o=0`.
- **Stop-bit error:** send 0x3C with stop bit 0 held low for 2 bit times, then high. Expect `frame_err_o=1` and `data_o=0x3C`. Expect no second strobe until a new start edge.
- **Glitch rejection:** at rate 0, drive `rx_i` low for 4 ticks, then high. Expect no `valid_o`, `busy_o` back to 0, state IDLE.
- **Other rates with sparse ticks:** `tick_i` pulsing every 3rd cycle. At rate 3 (OSR 2), send 0x81 and expect `data_o=0x81`. Repeat at rate 1 (OSR 8) with 0x7E.
- **Reset mid-frame:** pulse `rst_ni` low during the 4th data bit of 0xFF. Expect no strobe and all outputs reset. Then send 0x55 and expect exactly one strobe with `data_o=0x55`.
